// File: rtl/rv32_e_div_sequencer_pkg.sv
// Shared types for the execute-stage divider: ALU op codes,
// divider FSM states and op classification helpers.
package rv32_e_div_sequencer_pkg;

   localparam int ALU_CONTROL_WIDTH = 5;

   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_ADD  = 5'd0;
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SUB  = 5'd1;
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_AND  = 5'd2;
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OR   = 5'd3;
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_XOR  = 5'd4;
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_DIV  = 5'd12;
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_DIVU = 5'd13;
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_REM  = 5'd14;
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_REMU = 5'd15;

   typedef enum logic [2:0] {
      IDLE,
      DIVIDE,
      SIGNFIX,
      SPECIAL,
      FINISH
   } div_state_t;

   function automatic logic is_div_op(
      input logic [ALU_CONTROL_WIDTH-1:0] c
   );
      return (c == ALU_DIV)  || (c == ALU_DIVU) ||
             (c == ALU_REM)  || (c == ALU_REMU);
   endfunction

   function automatic logic is_signed_op(
      input logic [ALU_CONTROL_WIDTH-1:0] c
   );
      return (c == ALU_DIV) || (c == ALU_REM);
   endfunction

   function automatic logic is_rem_op(
      input logic [ALU_CONTROL_WIDTH-1:0] c
   );
      return (c == ALU_REM) || (c == ALU_REMU);
   endfunction

endpackage

// File: rtl/rv32_e_div_sequencer_if.sv
// Execute-stage <-> divider bundle: op issue, flush,
// pipeline stall and result return.
interface rv32_e_div_sequencer_if #(
   parameter int XLEN = 32
);
   import rv32_e_div_sequencer_pkg::*;

   logic                         start_i;
   logic [ALU_CONTROL_WIDTH-1:0] alu_control_i;
   logic [XLEN-1:0]              src_a_i;
   logic [XLEN-1:0]              src_b_i;
   logic                         flush_i;
   logic                         stall_o;
   logic                         done_o;
   logic [XLEN-1:0]              result_o;

   modport master (
      output start_i,
      output alu_control_i,
      output src_a_i,
      output src_b_i,
      output flush_i,
      input  stall_o,
      input  done_o,
      input  result_o
   );

   modport slave (
      input  start_i,
      input  alu_control_i,
      input  src_a_i,
      input  src_b_i,
      input  flush_i,
      output stall_o,
      output done_o,
      output result_o
   );

endinterface

// File: rtl/rv32_e_div_step.sv
// One restoring division step: shift in the next dividend bit,
// trial-subtract the divisor, keep or restore, emit quotient bit.
module rv32_e_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] div_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] shl;
   logic [XLEN:0] diff;

   // One extra bit: shl can reach 2*div-1, and diff's top bit is the borrow
   assign shl   = {rem_i, quo_i[XLEN-1]};
   assign diff  = shl - {1'b0, div_i};
   assign rem_o = diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
   assign quo_o = {quo_i[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/rv32_e_div_sequencer.sv
// Iterative DIV/DIVU/REM/REMU unit beside the EX-stage ALU;
// stalls the pipeline until the quotient or remainder is ready.
module rv32_e_div_sequencer
   import rv32_e_div_sequencer_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   rv32_e_div_sequencer_if.slave bus
);

   localparam int ITER = XLEN / UNROLL;
   localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

   div_state_t      state;
   logic [CW-1:0]   cnt;
   logic            rem_op;
   logic            neg_q;
   logic            neg_r;
   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] quo_q;
   logic [XLEN-1:0] dvs_q;
   logic [XLEN-1:0] res_q;
   logic            stall_q;
   logic            done_q;

   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            acc;
   logic            op_sgn;
   logic            op_rem;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] abs_a;
   logic [XLEN-1:0] abs_b;
   logic            div0;
   logic            ovf;
   logic [XLEN-1:0] sp_res;
   logic [XLEN-1:0] q_fix;
   logic [XLEN-1:0] r_fix;
   logic [XLEN-1:0] fix_res;

   assign a      = bus.src_a_i;
   assign b      = bus.src_b_i;
   assign op_sgn = is_signed_op(bus.alu_control_i);
   assign op_rem = is_rem_op(bus.alu_control_i);
   assign acc    = (state == IDLE) && bus.start_i &&
                   is_div_op(bus.alu_control_i) && !bus.flush_i;

   assign a_neg = op_sgn & a[XLEN-1];
   assign b_neg = op_sgn & b[XLEN-1];
   assign abs_a = a_neg ? -a : a;
   assign abs_b = b_neg ? -b : b;

   assign div0 = (b == '0);
   assign ovf  = op_sgn && (a == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (b == '1);

   // Short-path result is parked in the quotient register until SPECIAL
   assign sp_res = div0 ? (op_rem ? a : '1)
                        : (op_rem ? '0 : a);

   logic [XLEN-1:0] rem_c [UNROLL+1];
   logic [XLEN-1:0] quo_c [UNROLL+1];

   assign rem_c[0] = rem_q;
   assign quo_c[0] = quo_q;

   for (genvar i = 0; i < UNROLL; i++) begin : g_step
      rv32_e_div_step #(
         .XLEN (XLEN)
      ) u_step (
         .rem_i (rem_c[i]),
         .quo_i (quo_c[i]),
         .div_i (dvs_q),
         .rem_o (rem_c[i+1]),
         .quo_o (quo_c[i+1])
      );
   end

   assign q_fix   = neg_q ? -quo_q : quo_q;
   assign r_fix   = neg_r ? -rem_q : rem_q;
   assign fix_res = rem_op ? r_fix : q_fix;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         cnt     <= '0;
         rem_op  <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         res_q   <= '0;
         stall_q <= 1'b0;
         done_q  <= 1'b0;
      end else if (state != IDLE && bus.flush_i) begin
         state   <= IDLE;
         stall_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (acc) begin
                  rem_op  <= op_rem;
                  neg_q   <= a_neg ^ b_neg;
                  neg_r   <= a_neg;
                  rem_q   <= '0;
                  dvs_q   <= abs_b;
                  stall_q <= 1'b1;
                  if (div0 || ovf) begin
                     quo_q <= sp_res;
                     state <= SPECIAL;
                  end else begin
                     quo_q <= abs_a;
                     cnt   <= CW'(ITER - 1);
                     state <= DIVIDE;
                  end
               end
            end
            DIVIDE: begin
               rem_q <= rem_c[UNROLL];
               quo_q <= quo_c[UNROLL];
               cnt   <= cnt - 1'b1;
               if (cnt == '0) state <= SIGNFIX;
            end
            SIGNFIX: begin
               res_q   <= fix_res;
               done_q  <= 1'b1;
               stall_q <= 1'b0;
               state   <= FINISH;
            end
            SPECIAL: begin
               res_q   <= quo_q;
               done_q  <= 1'b1;
               stall_q <= 1'b0;
               state   <= FINISH;
            end
            FINISH: begin
               done_q  <= 1'b0;
               stall_q <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // IDLE must stall in the accept cycle itself, before any register updates
   assign bus.stall_o  = (state == IDLE) ? acc : stall_q;
   assign bus.done_o   = done_q;
   assign bus.result_o = res_q;

endmodule

// File: tb/tb_rv32_e_div_sequencer.sv
// Bench for rv32_e_div_sequencer: vectors, corner sequences and a
// random sweep on UNROLL 1/2/4 instances checked by a scoreboard.
module tb_rv32_e_div_sequencer;
   import rv32_e_div_sequencer_pkg::*;

   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                         start = 1'b0;
   logic [ALU_CONTROL_WIDTH-1:0] ctl = '0;
   logic [XLEN-1:0]              a = '0;
   logic [XLEN-1:0]              b = '0;
   logic                         flush = 1'b0;

   logic [2:0]      stall_w;
   logic [2:0]      done_w;
   logic [XLEN-1:0] res_w [3];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [XLEN-1:0] res;
      bit              sp;
      int              acc;
   } exp_t;

   typedef struct {
      logic [ALU_CONTROL_WIDTH-1:0] c;
      logic [XLEN-1:0]              x;
      logic [XLEN-1:0]              y;
      logic [XLEN-1:0]              r;
      bit                           sp;
   } vec_t;

   exp_t            exp_q [3][$];
   logic [XLEN-1:0] last_res [3];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int U  = 1 << g;
      localparam int IT = XLEN / U;

      rv32_e_div_sequencer_if #(.XLEN(XLEN)) bus ();

      assign bus.start_i       = start;
      assign bus.alu_control_i = ctl;
      assign bus.src_a_i       = a;
      assign bus.src_b_i       = b;
      assign bus.flush_i       = flush;
      assign stall_w[g]        = bus.stall_o;
      assign done_w[g]         = bus.done_o;
      assign res_w[g]          = bus.result_o;

      rv32_e_div_sequencer #(
         .XLEN   (XLEN),
         .UNROLL (U)
      ) dut (
         .clk_i  (clk),
         .rst_ni (rst_n),
         .bus    (bus)
      );

      always @(negedge clk) begin : mon
         exp_t e;
         if (bus.done_o) begin
            if (exp_q[g].size() == 0) begin
               tests++;
               fails++;
               $display("FAIL u%0d spurious done_o: result %h, required no pulse",
                        U, bus.result_o);
            end else begin
               e = exp_q[g].pop_front();
               last_res[g] = e.res;
               chk($sformatf("u%0d result", U), bus.result_o, e.res);
               chk($sformatf("u%0d latency", U), 32'(cyc - e.acc),
                   e.sp ? 32'd2 : 32'(IT + 2));
            end
         end
      end
   end

   function automatic logic [XLEN-1:0] model(
      input logic [ALU_CONTROL_WIDTH-1:0] c,
      input logic [XLEN-1:0] x,
      input logic [XLEN-1:0] y
   );
      logic rem = (c == ALU_REM) || (c == ALU_REMU);
      if (y == 0) return rem ? x : '1;
      if (c == ALU_DIV || c == ALU_REM) begin
         if (x == 32'h8000_0000 && y == '1) return rem ? '0 : x;
         return rem ? $signed(x) % $signed(y) : $signed(x) / $signed(y);
      end
      return rem ? x % y : x / y;
   endfunction

   task automatic drive_op(input logic [2:0] mask,
                           input logic [ALU_CONTROL_WIDTH-1:0] c,
                           input logic [XLEN-1:0] x,
                           input logic [XLEN-1:0] y,
                           input logic [XLEN-1:0] r,
                           input bit sp);
      exp_t e;
      start = 1'b1;
      ctl   = c;
      a     = x;
      b     = y;
      e.res = r;
      e.sp  = sp;
      e.acc = cyc;
      for (int k = 0; k < 3; k++)
         if (mask[k]) exp_q[k].push_back(e);
   endtask

   task automatic issue(input logic [ALU_CONTROL_WIDTH-1:0] c,
                        input logic [XLEN-1:0] x,
                        input logic [XLEN-1:0] y,
                        input logic [XLEN-1:0] r,
                        input bit sp);
      @(posedge clk);
      #1;
      drive_op(3'b111, c, x, y, r, sp);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
             exp_q[2].size() == 0) return;
      end
      tests++;
      fails++;
      $display("FAIL wait_idle: done_o never came, required within 200 cycles");
      for (int k = 0; k < 3; k++) exp_q[k].delete();
   endtask

   vec_t tv [14];

   initial begin : main
      logic [ALU_CONTROL_WIDTH-1:0] rc;
      logic [XLEN-1:0] rx;
      logic [XLEN-1:0] ry;
      bit              rsp;
      int              sel;

      tv[0]  = '{ALU_DIV,  32'd100,       32'd7,         32'd14,        1'b0};
      tv[1]  = '{ALU_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0};
      tv[2]  = '{ALU_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
      tv[3]  = '{ALU_REMU, 32'hFFFF_FFFF, 32'd16,        32'd15,        1'b0};
      tv[4]  = '{ALU_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
      tv[5]  = '{ALU_REMU, 32'd5,         32'd0,         32'd5,         1'b1};
      tv[6]  = '{ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
      tv[7]  = '{ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1};
      tv[8]  = '{ALU_DIV,  32'd0,         32'd1,         32'd0,         1'b0};
      tv[9]  = '{ALU_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0};
      tv[10] = '{ALU_DIV,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFE, 1'b0};
      tv[11] = '{ALU_REM,  32'd7,         32'hFFFF_FFFD, 32'd1,         1'b0};
      tv[12] = '{ALU_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1};
      tv[13] = '{ALU_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};

      #3;
      chk("reset stall_o", {29'd0, stall_w}, 32'd0);
      chk("reset done_o", {29'd0, done_w}, 32'd0);
      for (int k = 0; k < 3; k++)
         chk($sformatf("reset result u%0d", k), res_w[k], 32'd0);
      #9 rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         issue(tv[i].c, tv[i].x, tv[i].y, tv[i].r, tv[i].sp);
         wait_idle();
      end

      // Stall profile of the UNROLL=1 instance over a full DIV
      @(posedge clk);
      #1;
      drive_op(3'b111, ALU_DIV, 32'd100, 32'd7, 32'd14, 1'b0);
      for (int k = 0; k <= 35; k++) begin
         @(negedge clk);
         chk($sformatf("u1 stall_o N+%0d", k), {31'd0, stall_w[0]},
             32'(k <= 33));
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      wait_idle();

      for (int i = 0; i < 30; i++) begin
         sel = $urandom_range(0, 3);
         rc  = (sel == 0) ? ALU_DIV : (sel == 1) ? ALU_DIVU :
               (sel == 2) ? ALU_REM : ALU_REMU;
         rx  = $urandom;
         ry  = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) ry = '0;
         else if (sel == 1) begin
            rx = 32'h8000_0000;
            ry = '1;
         end else if (sel < 5) ry = 32'($urandom_range(1, 20));
         else if (sel == 5) ry = -32'($urandom_range(1, 20));
         rsp = (ry == 0) || ((rc == ALU_DIV || rc == ALU_REM) &&
                rx == 32'h8000_0000 && ry == '1);
         issue(rc, rx, ry, model(rc, rx, ry), rsp);
         wait_idle();
      end

      // Flush at the 10th DIVIDE cycle; UNROLL=4 is in FINISH then
      @(posedge clk);
      #1;
      drive_op(3'b100, ALU_DIV, 32'd100, 32'd7, 32'd14, 1'b0);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(negedge clk);
      chk("u1 stall_o in flush cycle", {31'd0, stall_w[0]}, 32'd1);
      @(posedge clk);
      #1;
      flush = 1'b0;
      #1;
      chk("stall_o after flush", {29'd0, stall_w}, 32'd0);
      chk("u1 result after flush", res_w[0], last_res[0]);
      chk("u2 result after flush", res_w[1], last_res[1]);
      drive_op(3'b111, ALU_DIV, 32'd9, 32'd3, 32'd3, 1'b0);
      @(negedge clk);
      chk("stall_o accept after flush", {29'd0, stall_w}, 32'd7);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle();

      // Asynchronous reset in the middle of DIVIDE
      @(posedge clk);
      #1;
      drive_op(3'b000, ALU_DIV, 32'd100, 32'd7, 32'd0, 1'b0);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid reset stall_o", {29'd0, stall_w}, 32'd0);
      chk("mid reset done_o", {29'd0, done_w}, 32'd0);
      for (int k = 0; k < 3; k++)
         chk($sformatf("mid reset result u%0d", k), res_w[k], 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      @(posedge clk);
      #1;
      start = 1'b1;
      ctl   = ALU_ADD;
      a     = 32'd5;
      b     = 32'd3;
      #1;
      chk("ALU_ADD stall_o", {29'd0, stall_w}, 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("ALU_ADD done_o", {29'd0, done_w}, 32'd0);

      for (int k = 0; k < 3; k++)
         chk($sformatf("u%0d pending results", k), 32'(exp_q[k].size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
